// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and helpers for the MLP output stage.
//   fp_t           default-width signed fixed-point score word
//   argmax_state_e argmax sequencer states
//   idx_width()    index width for a given class count (never below 1)
package mlp_pkg;

  localparam int FP_TOTAL_BITS_DFLT = 16;
  // Fractional bits only describe the number format; the argmax compares the
  // raw words, so no logic depends on this value.
  localparam int FP_FRAC_BITS_DFLT  = 8;

  typedef logic signed [FP_TOTAL_BITS_DFLT-1:0] fp_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: combinational best/second-best update for one candidate score.
//   cand_i, cand_idx_i  candidate score and its class index
//   best_i, best_idx_i  running best score and index
//   second_i            running second-best (only with ARGMAX_MARGIN_EN)
//   best_o, best_idx_o  updated best; strict greater-than, so ties keep the
//                       lower index already held
//   second_o            updated second-best (only with ARGMAX_MARGIN_EN)
// Build option: ARGMAX_MARGIN_EN adds the second-best tracking ports.
module argmax_cmp #(
  parameter int W     = 16,
  parameter int IDX_W = 2
) (
  input  logic signed [W-1:0]     cand_i,
  input  logic        [IDX_W-1:0] cand_idx_i,
  input  logic signed [W-1:0]     best_i,
  input  logic        [IDX_W-1:0] best_idx_i,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [W-1:0]     second_i,
  output logic signed [W-1:0]     second_o,
`endif
  output logic signed [W-1:0]     best_o,
  output logic        [IDX_W-1:0] best_idx_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
`ifdef ARGMAX_MARGIN_EN
    second_o   = second_i;
`endif
    if (cand_i > best_i) begin
      best_o     = cand_i;
      best_idx_o = cand_idx_i;
`ifdef ARGMAX_MARGIN_EN
      second_o   = best_i;
`endif
    end
`ifdef ARGMAX_MARGIN_EN
    else if (cand_i > second_i) begin
      second_o = cand_i;
    end
`endif
  end

endmodule

// File: rtl/argmax_unit.sv
// argmax_unit: sequential argmax over NUM_CLASSES signed scores, one class
// per cycle.
//   clk, reset  clock; synchronous active-high reset
//   start       request, scores sampled in the same cycle (ignored while busy)
//   scores      NUM_CLASSES signed scores
//   busy        high while in SCAN or DONE
//   done        one-cycle pulse, class_idx/max_score valid from then on
//   class_idx   index of the maximum (lowest index wins ties)
//   max_score   maximum score
//   margin      best minus second best, one bit wider (ARGMAX_MARGIN_EN only)
// Build option: ARGMAX_MARGIN_EN enables the margin port and second-best regs.
module argmax_unit
  import mlp_pkg::*;
#(
  parameter int  NUM_CLASSES   = 3,
  parameter int  FP_TOTAL_BITS = FP_TOTAL_BITS_DFLT,
  localparam int IDX_W         = idx_width(NUM_CLASSES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic signed [FP_TOTAL_BITS-1:0] scores [NUM_CLASSES],
  output logic                            busy,
  output logic                            done,
  output logic        [IDX_W-1:0]         class_idx,
  output logic signed [FP_TOTAL_BITS-1:0] max_score
`ifdef ARGMAX_MARGIN_EN
  ,output logic signed [FP_TOTAL_BITS:0]  margin
`endif
);

  localparam int W = FP_TOTAL_BITS;

  argmax_state_e           state_q, state_d;
  logic signed [W-1:0]     bank_q [NUM_CLASSES];
  logic        [IDX_W-1:0] ptr_q, ptr_d;
  logic signed [W-1:0]     best_q, best_d;
  logic        [IDX_W-1:0] best_idx_q, best_idx_d;
  logic                    done_q, done_d;
  logic        [IDX_W-1:0] class_idx_q, class_idx_d;
  logic signed [W-1:0]     max_score_q, max_score_d;
  logic                    capture;

  logic signed [W-1:0]     cand;
  logic signed [W-1:0]     cmp_best;
  logic        [IDX_W-1:0] cmp_best_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [W-1:0] FP_MIN = {1'b1, {(W-1){1'b0}}};
  logic signed [W-1:0]     second_q, second_d;
  logic signed [W-1:0]     cmp_second;
  logic signed [W:0]       margin_q, margin_d;
`endif

  // A single-class bank has no pointer to select with.
  if (NUM_CLASSES == 1) begin : g_cand_single
    assign cand = bank_q[0];
  end else begin : g_cand_multi
    assign cand = bank_q[ptr_q];
  end

  argmax_cmp #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .cand_i     (cand),
    .cand_idx_i (ptr_q),
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second_i   (second_q),
    .second_o   (cmp_second),
`endif
    .best_o     (cmp_best),
    .best_idx_o (cmp_best_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    done_d      = 1'b0;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
    capture     = 1'b0;
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          best_d     = scores[0];
          best_idx_d = '0;
          ptr_d      = IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
          second_d   = FP_MIN;
`endif
          state_d    = (NUM_CLASSES == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        best_d     = cmp_best;
        best_idx_d = cmp_best_idx;
`ifdef ARGMAX_MARGIN_EN
        second_d   = cmp_second;
`endif
        ptr_d      = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(NUM_CLASSES - 1)) state_d = DONE;
      end
      DONE: begin
        done_d      = 1'b1;
        class_idx_d = best_idx_q;
        max_score_d = best_q;
`ifdef ARGMAX_MARGIN_EN
        // Sign-extend both before subtracting so the full range fits.
        margin_d    = '0;
        if (NUM_CLASSES > 1) margin_d = {best_q[W-1], best_q} - {second_q[W-1], second_q};
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      done_q      <= 1'b0;
      class_idx_q <= '0;
      max_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      done_q      <= done_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

  // Score bank is pure data, only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (capture) bank_q <= scores;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign max_score = max_score_q;
`ifdef ARGMAX_MARGIN_EN
  assign margin    = margin_q;
`endif

endmodule
